// File: rtl/memory_burst_mc.sv
// memory_burst_mc: byte-addressed word memory with valid/ready requests, fixed latency and wrapping read bursts
module memory_burst_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY = 4,
  parameter int BURST_LEN = 4,
  parameter INIT_FILE = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_be,
  output logic                    rsp_valid,
  output logic                    rsp_last,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    busy
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int WW = ADDR_WIDTH - OFF;
  localparam int CW = $clog2(LATENCY + BURST_LEN) + 1;
  localparam logic [WW-1:0] MASK = WW'(BURST_LEN - 1);
  localparam logic [CW-1:0] WAIT_END = CW'(LATENCY > 1 ? LATENCY - 2 : 0);
  localparam logic [CW-1:0] BEAT_END = CW'(BURST_LEN - 1);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;
  logic [DATA_WIDTH-1:0] mem [2**WW];
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic wr_q;
  logic [WW-1:0] wi_q, beat_idx;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0] be_q;
  logic accept, xfer, last, unused_lsb;
  assign req_ready = state_q == S_IDLE && !rst;
  assign accept = req_valid && req_ready;
  assign xfer = state_q == S_XFER && !rst;
  assign last = wr_q || cnt_q == BEAT_END;
  assign beat_idx = (wi_q & ~MASK) | ((wi_q + WW'(cnt_q)) & MASK);
  assign rsp_valid = xfer;
  assign rsp_last = xfer && last;
  assign rsp_data = xfer && !wr_q ? mem[beat_idx] : '0;
  assign busy = state_q != S_IDLE;
  assign unused_lsb = ^req_addr[OFF-1:0];
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (state_q == S_IDLE) begin
      state_d = accept ? (LATENCY == 1 ? S_XFER : S_WAIT) : S_IDLE;
      cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      state_d = cnt_q == WAIT_END ? S_XFER : S_WAIT;
      cnt_d = cnt_q == WAIT_END ? '0 : cnt_q + CW'(1);
    end else begin
      state_d = last ? S_IDLE : S_XFER;
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q <= req_wr;
      wi_q <= req_addr[ADDR_WIDTH-1:OFF];
      wdata_q <= req_wdata;
      be_q <= req_be;
    end
  end
  always_ff @(posedge clk) begin
    if (xfer && wr_q)
      for (int i = 0; i < BW; i++)
        if (be_q[i]) mem[wi_q][8*i +: 8] <= wdata_q[8*i +: 8];
  end
endmodule

// File: tb/tb_memory_burst_mc.sv
// tb_memory_burst_mc: scoreboard bench for a default instance and a LATENCY=1/BURST_LEN=1 instance
module tb_memory_burst_mc;
  typedef struct {int c; logic [15:0] d; logic l;} beat_t;
  logic clk = 0, rst = 1;
  logic v [2], wr [2], rdy [2], rv [2], rl [2], bsy [2];
  logic [15:0] addr [2], wd [2], rd [2];
  logic [1:0] be [2];
  int n_vec = 0, n_bad = 0, cyc = 0, acc_cyc [2];
  bit mon_en = 0, abort = 0;
  beat_t q0 [$], q1 [$];
  logic [15:0] ref_mem [2][32768];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  memory_burst_mc dut0 (
    .clk(clk), .rst(rst), .req_valid(v[0]), .req_ready(rdy[0]), .req_wr(wr[0]),
    .req_addr(addr[0]), .req_wdata(wd[0]), .req_be(be[0]), .rsp_valid(rv[0]),
    .rsp_last(rl[0]), .rsp_data(rd[0]), .busy(bsy[0]));
  memory_burst_mc #(.LATENCY(1), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(v[1]), .req_ready(rdy[1]), .req_wr(wr[1]),
    .req_addr(addr[1]), .req_wdata(wd[1]), .req_be(be[1]), .rsp_valid(rv[1]),
    .rsp_last(rl[1]), .rsp_data(rd[1]), .busy(bsy[1]));
  function automatic int lat(int s); return s != 0 ? 1 : 4; endfunction
  function automatic int bl(int s); return s != 0 ? 1 : 4; endfunction
  function automatic int qn(int s); return s != 0 ? q1.size() : q0.size(); endfunction
  function automatic void push(int s, beat_t b);
    if (s != 0) q1.push_back(b); else q0.push_back(b);
  endfunction
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  task automatic mon(int s);
    beat_t b;
    if (rv[s]) begin
      if (qn(s) == 0) chk($sformatf("spurious_beat%0d", s), 1, 0);
      else begin
        if (s != 0) b = q1.pop_front(); else b = q0.pop_front();
        chk($sformatf("beat_cycle%0d", s), cyc, b.c);
        chk($sformatf("beat_data%0d", s), {16'h0, rd[s]}, {16'h0, b.d});
        chk($sformatf("beat_last%0d", s), {31'h0, rl[s]}, {31'h0, b.l});
      end
    end else chk($sformatf("idle_outputs%0d", s), {15'h0, rl[s], rd[s]}, 0);
  endtask
  always @(negedge clk) if (mon_en) begin mon(0); mon(1); end
  task automatic step_req(int s, bit w, logic [15:0] a, logic [15:0] d, logic [1:0] b, output bit acc);
    int wi, idx;
    @(negedge clk); #1;
    v[s] = 1; wr[s] = w; addr[s] = a; wd[s] = d; be[s] = b;
    #1;
    acc = rdy[s];
    if (acc) begin
      acc_cyc[s] = cyc;
      wi = int'(a >> 1);
      if (abort) ;
      else if (w) begin
        push(s, '{cyc + lat(s), 16'h0, 1'b1});
        for (int i = 0; i < 2; i++) if (b[i]) ref_mem[s][wi][8*i +: 8] = d[8*i +: 8];
      end else
        for (int k = 0; k < bl(s); k++) begin
          idx = (wi & ~(bl(s) - 1)) | ((wi + k) & (bl(s) - 1));
          push(s, '{cyc + lat(s) + k, ref_mem[s][idx], k == bl(s) - 1});
        end
    end
  endtask
  task automatic do_req(int s, bit w, logic [15:0] a, logic [15:0] d, logic [1:0] b);
    bit acc;
    int n = 0;
    do begin step_req(s, w, a, d, b, acc); n++; end while (!acc && n < 60);
    if (!acc) chk("accept_timeout", 0, 1);
    @(negedge clk); #1;
    v[s] = 0;
  endtask
  task automatic hold(int s, int steps, bit rnd, logic [15:0] a, output int na);
    bit acc;
    na = 0;
    for (int i = 0; i < steps; i++) begin
      step_req(s, 0, rnd ? 16'($urandom_range(0, 31)) : a, 16'h0, 2'b00, acc);
      na += int'(acc);
    end
    @(negedge clk); #1;
    v[s] = 0;
  endtask
  task automatic drain(int s);
    int n = 0;
    while ((qn(s) != 0 || bsy[s]) && n < 100) begin @(negedge clk); n++; end
    chk($sformatf("drain%0d", s), {31'h0, qn(s) != 0 || bsy[s]}, 0);
  endtask
  initial begin
    int c, na;
    for (int s = 0; s < 2; s++) begin
      v[s] = 0; wr[s] = 0; addr[s] = 0; wd[s] = 0; be[s] = 0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", {31'h0, rdy[0]}, 0);
    chk("rst_outputs", {13'h0, rv[0], rl[0], bsy[0], rd[0]}, 0);
    rst = 0;
    #1;
    chk("ready_after_rst", {31'h0, rdy[0]}, 1);
    mon_en = 1;
    for (int i = 0; i < 16; i++) do_req(0, 1, 16'(2 * i), i == 8 ? 16'h1234 : 16'(16'h1000 + i), 2'b11);
    for (int i = 0; i < 16; i++) do_req(0, 1, 16'(16'hFFE0 + 2 * i), 16'(16'h2000 + i), 2'b11);
    for (int i = 0; i < 4; i++) do_req(1, 1, 16'(2 * i), 16'(16'h1000 + i), 2'b11);
    drain(0); drain(1);
    do_req(0, 0, 16'h0006, 16'h0, 2'b00);
    c = acc_cyc[0];
    do_req(0, 0, 16'h0007, 16'h0, 2'b00);
    chk("read_ready_gap", acc_cyc[0] - c, 8);
    do_req(0, 1, 16'h0010, 16'hABCD, 2'b01);
    c = acc_cyc[0];
    do_req(0, 0, 16'h0010, 16'h0, 2'b00);
    chk("write_ready_gap", acc_cyc[0] - c, 5);
    do_req(0, 1, 16'h0012, 16'h5555, 2'b00);
    do_req(0, 0, 16'h0012, 16'h0, 2'b00);
    do_req(0, 1, 16'h0014, 16'h77AA, 2'b10);
    do_req(0, 0, 16'h0014, 16'h0, 2'b00);
    drain(0);
    hold(1, 10, 0, 16'h0002, na);
    chk("held_accepts_lat1", na, 5);
    drain(1);
    abort = 1;
    do_req(0, 1, 16'h0000, 16'hFFFF, 2'b11);
    abort = 0;
    chk("busy_before_rst", {31'h0, bsy[0]}, 1);
    @(negedge clk); #1;
    rst = 1;
    #1;
    chk("ready_in_rst", {31'h0, rdy[1]}, 0);
    @(negedge clk); #1;
    rst = 0;
    #1;
    chk("busy_after_rst", {31'h0, bsy[0]}, 0);
    do_req(0, 0, 16'h0000, 16'h0, 2'b00);
    drain(0);
    hold(0, 12, 1, 16'h0, na);
    chk("held_accepts", na, 2);
    drain(0);
    do_req(0, 0, 16'hFFFE, 16'h0, 2'b00);
    drain(0); drain(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
